result_streamer: RTL and testbench
==================================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 16, meaning the result word width.
REQ-002 SHALL have parameter INPUT_WIDTH, default 8, meaning the saturation target width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, meaning the result-memory address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, drain request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH, first word address, latched on accepted start.
REQ-008 SHALL have port count, input, ADDR_WIDTH+1, word count, latched on accepted start.
REQ-009 SHALL have port mem_addr, output, ADDR_WIDTH, result-memory read address (drives addrO).
REQ-010 SHALL have port mem_rdata, input, RESULT_WIDTH, read data (from dataO), valid one cycle after mem_addr.
REQ-011 SHALL have port m_valid, output, 1, stream beat valid.
REQ-012 SHALL have port m_ready, input, 1, stream beat accept.
REQ-013 SHALL have port m_data, output, RESULT_WIDTH, beat payload.
REQ-014 SHALL have port m_last, output, 1, final beat marker.
REQ-015 SHALL have port busy, output, 1, high outside IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, FINISH.
REQ-018 IDLE + start + count!=0 SHALL go to READ; start + count==0 SHALL go to FINISH with no beats.
REQ-019 READ SHALL issue addresses base_addr+i, i=0..count-1, modulo 2^ADDR_WIDTH, one per cycle when credit allows.
REQ-020 Credit rule: a read SHALL issue only if FIFO occupancy + in-flight reads < 4.
REQ-021 After the last issue READ SHALL go to DRAIN; DRAIN SHALL go to FINISH on the handshake of the m_last beat.
REQ-022 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 Handshake SHALL occur when m_valid && m_ready.
REQ-025 While m_valid && !m_ready, m_data/m_last SHALL hold; m_valid SHALL not drop.
REQ-026 First m_valid SHALL assert 3 cycles after the start edge, given no backpressure.
REQ-027 With m_ready held high, throughput SHALL be one beat per cycle.
REQ-028 m_last SHALL be high only with beat count-1; beats SHALL arrive in address order with no loss or duplication.
REQ-029 mem_addr SHALL hold its last value when not issuing.

Reset
REQ-030 Reset SHALL force IDLE; mem_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
REQ-031 Reset mid-operation SHALL discard in-flight reads and FIFO contents; the first start after release SHALL behave as from power-up.

Configuration
REQ-032 With RESULT_STREAM_SAT_EN defined, m_data SHALL be mem_rdata clamped to signed INPUT_WIDTH range [-2^(INPUT_WIDTH-1), 2^(INPUT_WIDTH-1)-1], sign-extended to RESULT_WIDTH; clamp SHALL add no latency.
REQ-033 Without RESULT_STREAM_SAT_EN, m_data SHALL equal mem_rdata unmodified.

Structure
REQ-034 Shared package systolic_pkg SHALL hold the FSM state enum, the FIFO depth constant (4) and default width constants.
REQ-035 A 4-entry synchronous FIFO SHALL be a sub-module named result_stream_fifo.

Verification
REQ-036 base 0, count 16, mem[i]=3*i, m_ready=1 -> beats 0,3,...,45 on 16 consecutive cycles, first 3 cycles after start, m_last on 16th, done one cycle later.
REQ-037 Same data, m_ready alternating 1/0 -> 16 correct beats, payload stable on stalls, no loss or duplication.
REQ-038 base 1022, count 4 -> mem_addr sequence 1022,1023,0,1; 4 beats in that order.
REQ-039 count 0 -> done pulse the cycle after FINISH entry, m_valid never high.
REQ-040 rst asserted after 5 of 16 beats -> all outputs 0 immediately; new start base 0 count 2 -> beats mem[0],mem[1].
REQ-041 RESULT_STREAM_SAT_EN, mem 0x0200 -> 0x007F, 0xFF00 -> 0xFF80, 0x0005 -> 0x0005; macro absent -> 0x0200 passes unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the result streaming path: FSM states, FIFO sizing
// and default widths.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } streamState_e;

  localparam int FIFO_DEPTH = 4;
  localparam int OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);

  localparam int DEFAULT_RESULT_WIDTH = 16;
  localparam int DEFAULT_INPUT_WIDTH  = 8;
  localparam int DEFAULT_ADDR_WIDTH   = 10;

endpackage

// File: rtl/result_stream_fifo.sv
// Small synchronous FIFO buffering result words between the memory read
// pipeline and the output stream. DEPTH must be a power of two.
module result_stream_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_RESULT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           pushData_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           popData_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign doPush = push_i && (count_q != CNT_W'(DEPTH));
  assign doPop  = pop_i && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/result_streamer.sv
// Drains a block of result memory onto a valid/ready stream with credit-based
// read issue. Define RESULT_STREAM_SAT_EN to clamp words to signed INPUT_WIDTH.
module result_streamer
  import systolic_pkg::*;
#(
  parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     count,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [RESULT_WIDTH-1:0] mem_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RESULT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = OCC_WIDTH + 1;

  streamState_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   nextAddr_q, nextAddr_d;
  logic [ADDR_WIDTH-1:0]   memAddr_q, memAddr_d;
  logic [ADDR_WIDTH:0]     wordCount_q, wordCount_d;
  logic [ADDR_WIDTH:0]     issueCnt_q, issueCnt_d;
  logic [ADDR_WIDTH:0]     beatCnt_q, beatCnt_d;
  logic                    rdPipe1_q;
  logic                    rdPipe2_q;

  logic                    issue;
  logic                    lastIssue;
  logic                    beatFire;
  logic [PW-1:0]           pending;
  logic [OCC_WIDTH-1:0]    fifoCount;
  logic                    fifoEmpty;
  logic [RESULT_WIDTH-1:0] fifoHead;
  logic [RESULT_WIDTH-1:0] pushData;

  // Reads already issued but not yet in the FIFO still hold a slot, so the
  // FIFO can never overflow however long the consumer stalls.
  assign pending   = PW'(fifoCount) + PW'(rdPipe1_q) + PW'(rdPipe2_q);
  assign issue     = (state_q == READ) && (pending < PW'(FIFO_DEPTH));
  assign lastIssue = issue && (issueCnt_q == wordCount_q - 1'b1);

  assign m_valid  = !fifoEmpty;
  assign beatFire = m_valid && m_ready;
  assign m_data   = m_valid ? fifoHead : '0;
  assign m_last   = m_valid && (beatCnt_q == wordCount_q - 1'b1);
  assign mem_addr = memAddr_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

`ifdef RESULT_STREAM_SAT_EN
  localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
    RESULT_WIDTH'((1 << (INPUT_WIDTH - 1)) - 1);
  localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    pushData = mem_rdata;
    if ($signed(mem_rdata) > SAT_MAX) begin
      pushData = SAT_MAX;
    end else if ($signed(mem_rdata) < SAT_MIN) begin
      pushData = SAT_MIN;
    end
  end
`else
  assign pushData = mem_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    nextAddr_d  = nextAddr_q;
    memAddr_d   = memAddr_q;
    wordCount_d = wordCount_q;
    issueCnt_d  = issueCnt_q;
    beatCnt_d   = beatCnt_q;

    if (issue) begin
      memAddr_d  = nextAddr_q;
      nextAddr_d = nextAddr_q + 1'b1;
      issueCnt_d = issueCnt_q + 1'b1;
    end
    if (beatFire) begin
      beatCnt_d = beatCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          nextAddr_d  = base_addr;
          wordCount_d = count;
          issueCnt_d  = '0;
          beatCnt_d   = '0;
          state_d     = (count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (lastIssue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beatFire && m_last) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      nextAddr_q  <= '0;
      memAddr_q   <= '0;
      wordCount_q <= '0;
      issueCnt_q  <= '0;
      beatCnt_q   <= '0;
      rdPipe1_q   <= 1'b0;
      rdPipe2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nextAddr_q  <= nextAddr_d;
      memAddr_q   <= memAddr_d;
      wordCount_q <= wordCount_d;
      issueCnt_q  <= issueCnt_d;
      beatCnt_q   <= beatCnt_d;
      rdPipe1_q   <= issue;
      rdPipe2_q   <= rdPipe1_q;
    end
  end

  result_stream_fifo #(
    .WIDTH(RESULT_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (rdPipe2_q),
    .pushData_i(pushData),
    .pop_i     (beatFire),
    .popData_o (fifoHead),
    .count_o   (fifoCount),
    .empty_o   (fifoEmpty)
  );

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: streaming, backpressure, address wrap,
// empty drain, mid-run reset and the optional saturation.
module tb_result_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [15:0] memModel [1024];

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int startEdge = 0;

  logic [15:0] beatData [$];
  logic        beatLast [$];
  int          beatCycle [$];
  logic [9:0]  addrSeq [$];
  int          doneCycle;
  int          doneHigh;
  bit          validSeen;
  int          stallErrors;
  bit          timedOut;

  result_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read result memory: data appears one cycle after the address.
  always @(posedge clk) mem_rdata <= memModel[mem_addr];

  always @(posedge clk) cycleCount++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Pulse start for the next rising edge; startEdge is that edge's index.
  task automatic applyStimulus(input logic [9:0] base, input logic [10:0] cnt);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    startEdge = cycleCount + 1;
  endtask

  // Runs cycles until two cycles after done, recording beats, addresses and
  // stall behaviour. Inputs change at the negedge, then outputs are sampled.
  task automatic collectBeats(input int maxCycles, input bit altReady, input int pokeAt);
    logic        prevStall;
    logic [15:0] prevData;
    logic        prevLast;
    logic [9:0]  prevAddr;
    int          doneIdx;
    beatData.delete();
    beatLast.delete();
    beatCycle.delete();
    addrSeq.delete();
    doneCycle   = -1;
    doneHigh    = 0;
    validSeen   = 1'b0;
    stallErrors = 0;
    timedOut    = 1'b1;
    prevStall   = 1'b0;
    prevData    = '0;
    prevLast    = 1'b0;
    prevAddr    = mem_addr;
    doneIdx     = -1;
    m_ready     = 1'b1;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == pokeAt) begin
        start     = 1'b1;
        base_addr = 10'd500;
        count     = 11'd3;
      end
      if (altReady && i > 0) m_ready = ~m_ready;
      if (prevStall && (!m_valid || m_data !== prevData || m_last !== prevLast)) stallErrors++;
      if (m_valid) validSeen = 1'b1;
      if (mem_addr !== prevAddr) begin
        addrSeq.push_back(mem_addr);
        prevAddr = mem_addr;
      end
      if (m_valid && m_ready) begin
        beatData.push_back(m_data);
        beatLast.push_back(m_last);
        beatCycle.push_back(cycleCount);
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
      if (done) begin
        doneHigh++;
        if (doneIdx < 0) begin
          doneIdx   = i;
          doneCycle = cycleCount;
        end
      end
      if (doneIdx >= 0 && i >= doneIdx + 2) begin
        timedOut = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (mem_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_last: got %b%b expected 00", m_valid, m_last); end
    checks++;
    if (m_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 0000", m_data); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
  endtask

  task automatic test_stream();
    applyStimulus(10'd0, 11'd16);
    collectBeats(100, 1'b0, -1);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL stream_timeout: got no done, expected done"); end
    checks++;
    if (beatData.size() != 16) begin errors++; $display("[TB] FAIL stream_beats: got %0d expected 16", beatData.size()); end
    for (int i = 0; i < beatData.size() && i < 16; i++) begin
      checks++;
      if (beatData[i] !== 16'(3 * i) || beatLast[i] !== (i == 15)) begin
        errors++;
        $display("[TB] FAIL stream_beat[%0d]: got %h last %b expected %h last %b", i, beatData[i], beatLast[i], 16'(3 * i), (i == 15));
      end
      checks++;
      if (beatCycle[i] != startEdge + 3 + i) begin
        errors++;
        $display("[TB] FAIL stream_cycle[%0d]: got %0d expected %0d", i, beatCycle[i] - startEdge, 3 + i);
      end
    end
    checks++;
    if (doneCycle != startEdge + 19 || doneHigh != 1) begin
      errors++;
      $display("[TB] FAIL stream_done: got cycle %0d width %0d expected cycle 19 width 1", doneCycle - startEdge, doneHigh);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stream_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    applyStimulus(10'd0, 11'd16);
    collectBeats(200, 1'b1, 6);
    checks++;
    if (timedOut !== 1'b0 || beatData.size() != 16) begin
      errors++;
      $display("[TB] FAIL bp_beats: got %0d beats timeout %b expected 16 beats timeout 0", beatData.size(), timedOut);
    end
    for (int i = 0; i < beatData.size() && i < 16; i++) begin
      checks++;
      if (beatData[i] !== 16'(3 * i) || beatLast[i] !== (i == 15)) begin
        errors++;
        $display("[TB] FAIL bp_beat[%0d]: got %h last %b expected %h last %b", i, beatData[i], beatLast[i], 16'(3 * i), (i == 15));
      end
    end
    checks++;
    if (stallErrors != 0) begin errors++; $display("[TB] FAIL bp_stall_hold: got %0d violations expected 0", stallErrors); end
    checks++;
    if (doneHigh != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_done: got width %0d busy %b expected width 1 busy 0", doneHigh, busy);
    end
  endtask

  task automatic test_wrap();
    logic [9:0]  expAddr [4];
    logic [15:0] expData [4];
    expAddr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    expData = '{16'd3066, 16'd3069, 16'd0, 16'd3};
    applyStimulus(10'd1022, 11'd4);
    collectBeats(100, 1'b0, -1);
    checks++;
    if (addrSeq.size() != 4 || beatData.size() != 4) begin
      errors++;
      $display("[TB] FAIL wrap_sizes: got %0d addrs %0d beats expected 4 and 4", addrSeq.size(), beatData.size());
    end
    for (int i = 0; i < addrSeq.size() && i < 4; i++) begin
      checks++;
      if (addrSeq[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, addrSeq[i], expAddr[i]); end
    end
    for (int i = 0; i < beatData.size() && i < 4; i++) begin
      checks++;
      if (beatData[i] !== expData[i] || beatLast[i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL wrap_beat[%0d]: got %0d last %b expected %0d last %b", i, beatData[i], beatLast[i], expData[i], (i == 3));
      end
    end
  endtask

  task automatic test_count_zero();
    applyStimulus(10'd7, 11'd0);
    collectBeats(20, 1'b0, -1);
    checks++;
    if (doneCycle != startEdge || doneHigh != 1) begin
      errors++;
      $display("[TB] FAIL zero_done: got cycle %0d width %0d expected cycle 0 width 1", doneCycle - startEdge, doneHigh);
    end
    checks++;
    if (validSeen !== 1'b0 || beatData.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_no_beats: got valid %b beats %0d expected 0 and 0", validSeen, beatData.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    applyStimulus(10'd0, 11'd16);
    m_ready = 1'b1;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) n++;
    end
    checks++;
    if (n != 5) begin errors++; $display("[TB] FAIL rstmid_progress: got %0d beats expected 5", n); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got addr %0d v %b d %h l %b b %b dn %b expected all 0", mem_addr, m_valid, m_data, m_last, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(10'd0, 11'd2);
    collectBeats(50, 1'b0, -1);
    checks++;
    if (beatData.size() != 2) begin
      errors++;
      $display("[TB] FAIL rstmid_beats: got %0d expected 2", beatData.size());
    end else begin
      checks++;
      if (beatData[0] !== 16'd0 || beatData[1] !== 16'd3 || beatLast[0] !== 1'b0 || beatLast[1] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rstmid_data: got %h/%b %h/%b expected 0000/0 0003/1", beatData[0], beatLast[0], beatData[1], beatLast[1]);
      end
      checks++;
      if (beatCycle[0] != startEdge + 3) begin
        errors++;
        $display("[TB] FAIL rstmid_latency: got %0d expected 3", beatCycle[0] - startEdge);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] expData [3];
`ifdef RESULT_STREAM_SAT_EN
    expData = '{16'h007F, 16'hFF80, 16'h0005};
`else
    expData = '{16'h0200, 16'hFF00, 16'h0005};
`endif
    memModel[100] = 16'h0200;
    memModel[101] = 16'hFF00;
    memModel[102] = 16'h0005;
    applyStimulus(10'd100, 11'd3);
    collectBeats(50, 1'b0, -1);
    checks++;
    if (beatData.size() != 3) begin errors++; $display("[TB] FAIL sat_beats: got %0d expected 3", beatData.size()); end
    for (int i = 0; i < beatData.size() && i < 3; i++) begin
      checks++;
      if (beatData[i] !== expData[i]) begin errors++; $display("[TB] FAIL sat_data[%0d]: got %h expected %h", i, beatData[i], expData[i]); end
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) memModel[a] = 16'(3 * a);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    m_ready   = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_stream();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_reset_mid();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
